// File: rtl/soccer_pkg.sv
// ----------------------------------------------------------------------------
// soccer_pkg
//   Shared types and constants for the player motion engine.
//   motion_state_t : RUN / RECENTER / FREEZE motion FSM states
//   FIELD_*        : default inclusive field edges
//   *_START_DEF    : default kickoff (recenter) position
// ----------------------------------------------------------------------------
package soccer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RECENTER = 2'd1,
    FREEZE   = 2'd2
  } motion_state_t;

  localparam int FIELD_X_MIN = 0;
  localparam int FIELD_X_MAX = 639;
  localparam int FIELD_Y_MIN = 0;
  localparam int FIELD_Y_MAX = 479;
  localparam int X_START_DEF = 210;
  localparam int Y_START_DEF = 240;

endpackage

// File: rtl/motion_axis.sv
// ----------------------------------------------------------------------------
// motion_axis
//   One axis of the sprite motion engine: key-pair target velocity, accel
//   ramp, speed cap, friction decay, and position clamp against the field.
//   i_clk/i_rst_n  : frame clock, synchronous active-low reset
//   i_recenter     : force position to START and velocity to 0
//   i_run          : velocity update and position integration enabled
//   i_fric_tick    : friction frame (applies only when the axis is undriven)
//   i_key_pos/neg  : direction keys (pos = right/down)
//   i_max_speed, i_accel, i_fric_step : unsigned motion controls
//   i_size         : sprite half-size for this edge (already animated)
//   o_pos, o_vel   : registered position, signed velocity
// ----------------------------------------------------------------------------
module motion_axis
  import soccer_pkg::*;
#(
  parameter int W     = 10,
  parameter int MIN   = 0,
  parameter int MAX   = 639,
  parameter int START = 210
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_recenter,
  input  logic         i_run,
  input  logic         i_fric_tick,
  input  logic         i_key_pos,
  input  logic         i_key_neg,
  input  logic [W-1:0] i_max_speed,
  input  logic [W-1:0] i_accel,
  input  logic [W-1:0] i_fric_step,
  input  logic [W-1:0] i_size,
  output logic [W-1:0] o_pos,
  output logic [W-1:0] o_vel
);

  // Two guard bits keep pos+vel and edge-minus-size tests sign-correct.
  localparam int WE = W + 2;

  logic [W-1:0] r_pos, r_vel;
  logic signed [WE-1:0] w_vel, w_pos, w_max, w_acc, w_fric, w_size, w_tgt;
  logic signed [WE-1:0] w_vel_upd, w_step, w_nxt, w_lo, w_hi, w_pos_c, w_vel_c;
  logic w_drive;

  assign w_vel   = $signed({{2{r_vel[W-1]}}, r_vel});
  assign w_pos   = $signed({2'b00, r_pos});
  assign w_max   = $signed({2'b00, i_max_speed});
  assign w_acc   = $signed({2'b00, i_accel});
  assign w_fric  = $signed({2'b00, i_fric_step});
  assign w_size  = $signed({2'b00, i_size});
  assign w_lo    = $signed(WE'(MIN)) + w_size;
  assign w_hi    = $signed(WE'(MAX)) - w_size;
  // Exactly one key of the pair drives the axis; both or neither coast.
  assign w_drive = i_key_pos ^ i_key_neg;
  assign w_tgt   = i_key_pos ? w_max : -w_max;

  always_comb begin
    w_vel_upd = w_vel;
    if (w_drive) begin
      if ((w_vel > w_max) || (w_vel < -w_max))
        w_vel_upd = w_vel[WE-1] ? -w_max : w_max;   // cap was lowered
      else if (w_tgt - w_vel > w_acc)
        w_vel_upd = w_vel + w_acc;
      else if (w_vel - w_tgt > w_acc)
        w_vel_upd = w_vel - w_acc;
      else
        w_vel_upd = w_tgt;                          // land without overshoot
    end else if (i_fric_tick) begin
      if (w_vel > w_fric)
        w_vel_upd = w_vel - w_fric;
      else if (w_vel < -w_fric)
        w_vel_upd = w_vel + w_fric;
      else
        w_vel_upd = '0;
    end
  end

  // Position uses the velocity held before this edge; the clamp uses the
  // new size so a growing sprite is pushed back inside the field.
  always_comb begin
    w_step = w_vel;
    if (!i_run) w_step = '0;
    w_nxt   = w_pos + w_step;
    w_pos_c = w_nxt;
    w_vel_c = i_run ? w_vel_upd : w_vel;
    if (w_nxt < w_lo) begin
      w_pos_c = w_lo;
      w_vel_c = '0;
    end else if (w_nxt > w_hi) begin
      w_pos_c = w_hi;
      w_vel_c = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_recenter) begin
      r_pos <= W'(START);
      r_vel <= '0;
    end else begin
      r_pos <= w_pos_c[W-1:0];
      r_vel <= w_vel_c[W-1:0];
    end
  end

  assign o_pos = r_pos;
  assign o_vel = r_vel;

endmodule

// File: rtl/player_motion_ctrl.sv
// ----------------------------------------------------------------------------
// player_motion_ctrl
//   Per-player sprite motion engine stepped once per frame_clk (vsync).
//   Holds the RUN/RECENTER/FREEZE FSM, friction divider, kickoff hold counter
//   and size animation; per-axis dynamics live in two motion_axis instances.
//   frame_clk, Reset (sync, active low), center_req (level)
//   keycode[31:0]  : key bitmap, only the KEY_* bits are read
//   max_speed, accel, fric_step, target_size : unsigned controls
//   pos_x/pos_y, vel_x/vel_y (signed), size, frozen : registered outputs
// ----------------------------------------------------------------------------
module player_motion_ctrl
  import soccer_pkg::*;
#(
  parameter int W           = 10,
  parameter int X_START     = X_START_DEF,
  parameter int Y_START     = Y_START_DEF,
  parameter int X_MIN       = FIELD_X_MIN,
  parameter int X_MAX       = FIELD_X_MAX,
  parameter int Y_MIN       = FIELD_Y_MIN,
  parameter int Y_MAX       = FIELD_Y_MAX,
  parameter int KEY_UP      = 9,
  parameter int KEY_LEFT    = 8,
  parameter int KEY_DOWN    = 7,
  parameter int KEY_RIGHT   = 6,
  parameter int FRIC_DIV    = 4,
  parameter int HOLD_FRAMES = 60
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         center_req,
  input  logic [31:0]  keycode,
  input  logic [W-1:0] max_speed,
  input  logic [W-1:0] accel,
  input  logic [W-1:0] fric_step,
  input  logic [W-1:0] target_size,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [W-1:0] vel_x,
  output logic [W-1:0] vel_y,
  output logic [W-1:0] size,
  output logic         frozen
);

  localparam int FCW = (FRIC_DIV > 1) ? $clog2(FRIC_DIV) : 1;
  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FCW-1:0] FRIC_LAST = FCW'(FRIC_DIV - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

  motion_state_t  r_state;
  logic [FCW-1:0] r_fric_cnt;
  logic [HCW-1:0] r_hold_cnt;
  logic [W-1:0]   r_size;
  logic           r_frozen;

  logic [W-1:0] w_size_nxt;
  logic         w_run, w_fric_tick, w_unused_keys;

  assign w_unused_keys = ^keycode;

  // center_req outranks the current state, so RUN only counts without it.
  assign w_run       = (r_state == RUN) && !center_req;
  assign w_fric_tick = w_run && (r_fric_cnt == FRIC_LAST);

  always_comb begin
    w_size_nxt = r_size;
    if (r_size < target_size)      w_size_nxt = r_size + W'(1);
    else if (r_size > target_size) w_size_nxt = r_size - W'(1);
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      r_state    <= RUN;
      r_fric_cnt <= '0;
      r_hold_cnt <= '0;
      r_size     <= target_size;
      r_frozen   <= 1'b0;
    end else begin
      r_size <= w_size_nxt;
      if (center_req) begin
        r_state    <= RECENTER;
        r_fric_cnt <= '0;
        r_hold_cnt <= '0;
        r_frozen   <= 1'b1;
      end else begin
        case (r_state)
          RUN: begin
            r_fric_cnt <= w_fric_tick ? '0 : r_fric_cnt + FCW'(1);
            r_frozen   <= 1'b0;
          end
          RECENTER: begin
            r_fric_cnt <= '0;
            r_hold_cnt <= '0;
            if (HOLD_FRAMES == 0) begin
              r_state  <= RUN;
              r_frozen <= 1'b0;
            end else begin
              r_state  <= FREEZE;
              r_frozen <= 1'b1;
            end
          end
          FREEZE: begin
            r_fric_cnt <= '0;
            // Entered with count 0, so the freeze spans HOLD_FRAMES frames.
            if (r_hold_cnt == HOLD_LAST) begin
              r_state    <= RUN;
              r_hold_cnt <= '0;
              r_frozen   <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HCW'(1);
              r_frozen   <= 1'b1;
            end
          end
          default: begin
            r_state  <= RUN;
            r_frozen <= 1'b0;
          end
        endcase
      end
    end
  end

  motion_axis #(.W(W), .MIN(X_MIN), .MAX(X_MAX), .START(X_START)) u_axis_x (
    .i_clk       (frame_clk),
    .i_rst_n     (Reset),
    .i_recenter  (center_req),
    .i_run       (w_run),
    .i_fric_tick (w_fric_tick),
    .i_key_pos   (keycode[KEY_RIGHT]),
    .i_key_neg   (keycode[KEY_LEFT]),
    .i_max_speed (max_speed),
    .i_accel     (accel),
    .i_fric_step (fric_step),
    .i_size      (w_size_nxt),
    .o_pos       (pos_x),
    .o_vel       (vel_x)
  );

  motion_axis #(.W(W), .MIN(Y_MIN), .MAX(Y_MAX), .START(Y_START)) u_axis_y (
    .i_clk       (frame_clk),
    .i_rst_n     (Reset),
    .i_recenter  (center_req),
    .i_run       (w_run),
    .i_fric_tick (w_fric_tick),
    .i_key_pos   (keycode[KEY_DOWN]),
    .i_key_neg   (keycode[KEY_UP]),
    .i_max_speed (max_speed),
    .i_accel     (accel),
    .i_fric_step (fric_step),
    .i_size      (w_size_nxt),
    .o_pos       (pos_y),
    .o_vel       (vel_y)
  );

  assign size   = r_size;
  assign frozen = r_frozen;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_player_motion_ctrl
//   Directed bench: a table of per-frame key inputs with hand-computed
//   positions/velocities, then hand-written sequences for the wall clamp,
//   recenter + kickoff freeze, reset during freeze and size growth at a wall.
// ----------------------------------------------------------------------------
module tb_player_motion_ctrl;

  localparam int W    = 10;
  localparam int HOLD = 8;

  logic         frame_clk = 1'b0;
  logic         Reset = 1'b0;
  logic         center_req = 1'b0;
  logic [31:0]  keycode = '0;
  logic [W-1:0] max_speed = 10'd4;
  logic [W-1:0] accel = 10'd1;
  logic [W-1:0] fric_step = 10'd1;
  logic [W-1:0] target_size = 10'd10;
  logic [W-1:0] pos_x, pos_y, vel_x, vel_y, size;
  logic         frozen;

  int n_cmp = 0;
  int n_err = 0;

  player_motion_ctrl #(.W(W), .HOLD_FRAMES(HOLD)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .center_req  (center_req),
    .keycode     (keycode),
    .max_speed   (max_speed),
    .accel       (accel),
    .fric_step   (fric_step),
    .target_size (target_size),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .vel_x       (vel_x),
    .vel_y       (vel_y),
    .size        (size),
    .frozen      (frozen)
  );

  always #5 frame_clk = ~frame_clk;

  // keys field: {UP, LEFT, DOWN, RIGHT}
  typedef struct {
    logic [3:0] keys;
    int px, py, vx, vy;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_true(input string nm, input bit ok, input int act);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, condition not met", nm, act);
    end
  endtask

  task automatic frame();
    @(negedge frame_clk);
  endtask

  task automatic set_keys(input logic [3:0] k);
    keycode    = '0;
    keycode[9] = k[3];
    keycode[8] = k[2];
    keycode[7] = k[1];
    keycode[6] = k[0];
  endtask

  task automatic chk_state(input string tag, input int px, input int py,
                           input int vx, input int vy, input int frz);
    chk({tag, " pos_x"}, int'(pos_x), px);
    chk({tag, " pos_y"}, int'(pos_y), py);
    chk({tag, " vel_x"}, int'($signed(vel_x)), vx);
    chk({tag, " vel_y"}, int'($signed(vel_y)), vy);
    chk({tag, " frozen"}, int'(frozen), frz);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    frame();
    Reset = 1'b1;
  endtask

  initial begin
    int  nfrz;
    bit  seen;
    // RIGHT ramp, coast with friction every 4th RUN frame, then L+R+UP.
    tbl[0]  = '{4'b0001, 210, 240, 1, 0};
    tbl[1]  = '{4'b0001, 211, 240, 2, 0};
    tbl[2]  = '{4'b0001, 213, 240, 3, 0};
    tbl[3]  = '{4'b0001, 216, 240, 4, 0};
    tbl[4]  = '{4'b0001, 220, 240, 4, 0};
    tbl[5]  = '{4'b0000, 224, 240, 4, 0};
    tbl[6]  = '{4'b0000, 228, 240, 4, 0};
    tbl[7]  = '{4'b0000, 232, 240, 3, 0};
    tbl[8]  = '{4'b0000, 235, 240, 3, 0};
    tbl[9]  = '{4'b0000, 238, 240, 3, 0};
    tbl[10] = '{4'b0000, 241, 240, 3, 0};
    tbl[11] = '{4'b0000, 244, 240, 2, 0};
    tbl[12] = '{4'b0000, 246, 240, 2, 0};
    tbl[13] = '{4'b0000, 248, 240, 2, 0};
    tbl[14] = '{4'b0000, 250, 240, 2, 0};
    tbl[15] = '{4'b0000, 252, 240, 1, 0};
    tbl[16] = '{4'b0000, 253, 240, 1, 0};
    tbl[17] = '{4'b0000, 254, 240, 1, 0};
    tbl[18] = '{4'b0000, 255, 240, 1, 0};
    tbl[19] = '{4'b0000, 256, 240, 0, 0};
    tbl[20] = '{4'b0000, 256, 240, 0, 0};
    tbl[21] = '{4'b0001, 256, 240, 1, 0};
    tbl[22] = '{4'b0001, 257, 240, 2, 0};
    tbl[23] = '{4'b1101, 259, 240, 1, -1};
    tbl[24] = '{4'b1101, 260, 239, 1, -2};
    tbl[25] = '{4'b1101, 261, 237, 1, -3};
    tbl[26] = '{4'b1101, 262, 234, 1, -4};
    tbl[27] = '{4'b1101, 263, 230, 0, -4};
    tbl[28] = '{4'b1101, 263, 226, 0, -4};

    // Reset state
    Reset = 1'b0;
    frame();
    chk_state("reset", 210, 240, 0, 0, 0);
    chk("reset size", int'(size), 10);
    Reset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      set_keys(tbl[i].keys);
      frame();
      chk_state($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].vx, tbl[i].vy, 0);
    end

    // Left wall: size 10 means pos_x never goes below 10.
    set_keys(4'b0000);
    do_reset();
    set_keys(4'b0100);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      frame();
      chk_true("wall pos_x>=10", int'(pos_x) >= 10 && int'(pos_x) <= 210, int'(pos_x));
      if (pos_x == 10'd10) begin
        seen = 1'b1;
        chk("wall vel_x", int'($signed(vel_x)), 0);
      end
    end
    chk("wall reached", int'(seen), 1);

    // Recenter pulse mid-run, then a freeze of exactly HOLD frames.
    set_keys(4'b0000);
    do_reset();
    set_keys(4'b0001);
    frame(); frame(); frame();
    chk_state("prerc", 213, 240, 3, 0, 0);
    center_req = 1'b1;
    frame();
    chk_state("recenter", 210, 240, 0, 0, 1);
    center_req = 1'b0;
    nfrz = 0;
    for (int i = 0; i < 200; i++) begin
      frame();
      if (!frozen) break;
      nfrz++;
      chk_state($sformatf("freeze%0d", nfrz), 210, 240, 0, 0, 1);
    end
    chk("freeze frames", nfrz, HOLD);
    chk_state("unfrozen", 210, 240, 0, 0, 0);
    frame();
    chk_state("run after freeze", 210, 240, 1, 0, 0);

    // Reset during FREEZE returns straight to RUN.
    center_req = 1'b1;
    frame();
    center_req = 1'b0;
    frame(); frame(); frame();
    chk("in freeze", int'(frozen), 1);
    do_reset();
    chk_state("reset in freeze", 210, 240, 0, 0, 0);
    chk("reset in freeze size", int'(size), 10);
    frame();
    chk_state("run after reset", 210, 240, 1, 0, 0);

    // Right wall, then grow size 10 -> 14 against it.
    set_keys(4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      frame();
      chk_true("rwall pos_x<=629", int'(pos_x) <= 629, int'(pos_x));
      if (pos_x == 10'd629 && vel_x == '0) seen = 1'b1;
    end
    chk("rwall reached", int'(seen), 1);
    set_keys(4'b0000);
    frame();
    chk_state("rwall rest", 629, 240, 0, 0, 0);
    target_size = 10'd14;
    for (int s = 11; s <= 15; s++) begin
      frame();
      chk($sformatf("grow size%0d", s), int'(size), (s > 14) ? 14 : s);
      chk($sformatf("grow pos_x%0d", s), int'(pos_x), 639 - ((s > 14) ? 14 : s));
      chk($sformatf("grow vel_x%0d", s), int'($signed(vel_x)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
